axi_sram_slave: RTL
===================

Name: axi_sram_slave

Overview:
- AXI3 responder (slave) bridging AXI read/write channels to one single-port synchronous SRAM with 1-cycle read latency.
- Serves as the memory-side endpoint for the CPU's AXI master bridge in the SoC-lite simulation/FPGA environment, replacing the vendor AXI RAM IP.
- Read and write engines are independent and share the SRAM port through a round-robin arbiter.
- Supports INCR and FIXED bursts of up to 16 beats.

Parameters:
- ADDR_W, 16, SRAM word-address width; the SRAM depth is 2^ADDR_W words of 32 bits.
- ID_W, 4, width of the AXI ID fields.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot  in  ID_W/32/8/3/2/2/4/3  AR channel payload.
- arvalid  in  1.
- arready  out  1.
- rid/rdata/rresp/rlast  out  ID_W/32/2/1  R channel payload.
- rvalid  out  1.
- rready  in  1.
- awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot  in  same widths as AR  AW channel payload.
- awvalid  in  1.
- awready  out  1.
- wid/wdata/wstrb/wlast  in  ID_W/32/4/1  W channel payload.
- wvalid  in  1.
- wready  out  1.
- bid/bresp  out  ID_W/2  B channel payload.
- bvalid  out  1.
- bready  in  1.
- ram_en  out  1  SRAM access enable.
- ram_we  out  4  byte write enables; 0 means read.
- ram_addr  out  ADDR_W  SRAM word address.
- ram_wdata  out  32  SRAM write data.
- ram_rdata  in  32  SRAM read data, valid the cycle after a read ram_en.

Behaviour:
- Reset (async, active-high): both FSMs go to IDLE; every output is 0 except arready=1 and awready=1; the arbiter's last-grant flag goes to READ. Any in-flight transaction is dropped with no response.
- Address registers and beat counters:
  - Loaded on the AR/AW handshake.
  - Beat count = len[3:0]+1; len[7:4] are ignored.
  - Next address: FIXED keeps the address. INCR and WRAP (WRAP treated as INCR) add 1<<min(size,2) bytes.
  - ram_addr = addr[ADDR_W+1:2].
  - This calculation lives in the sub-module.
- Read FSM:
  - R_IDLE: arready=1. On arvalid, latch id/addr/len/burst and go to R_REQ.
  - R_REQ: request the port. When granted, ram_en=1, ram_we=0, then go to R_CAP.
  - R_CAP: capture ram_rdata into the rdata register and go to R_DATA.
  - R_DATA: rvalid=1, with rid, rdata, rresp and rlast held stable until rready. On handshake: if it was the last beat, go to R_IDLE; otherwise step the address and go to R_REQ.
  - Timing: AR handshake at cycle T, ram_en at T+1, first rvalid at T+3 when uncontended.
  - rlast = 1 on the final beat only.
  - rresp = SLVERR (2'b10) for every beat when arburst==2'b11; otherwise OKAY. Data is still read.
- Write FSM:
  - W_IDLE: awready=1. On awvalid, latch the AW fields and go to W_DATA.
  - W_DATA: wready = grant (combinational). On wvalid&&wready: ram_en=1, ram_we=wstrb, ram_wdata=wdata in the same cycle. The beat counter steps; after the final counted beat go to W_RESP.
  - Error flag: set if wlast mismatches the counter (asserted early or missing on the final beat), or if awburst==2'b11.
  - W_RESP: bvalid=1, bid=latched awid, bresp = SLVERR if the error flag is set, else OKAY. Hold until bready, then go to W_IDLE.
  - wid is ignored (no interleaving).
- Arbiter:
  - A sole requester is granted immediately.
  - Simultaneous read and write requests: grant the side not granted at the last conflict, then toggle the flag.
  - There is never more than one ram_en per cycle.
- The arlock/arcache/arprot and awlock/awcache/awprot fields are accepted and ignored.
- arsize/awsize greater than 2 are treated as 2.

Decomposition:
- Package axi_slv_pkg:
  - RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10.
  - BURST_FIXED / BURST_INCR / BURST_WRAP / BURST_RSVD.
  - Read FSM state encodings: R_IDLE, R_REQ, R_CAP, R_DATA.
  - Write FSM state encodings: W_IDLE, W_DATA, W_RESP.
- Sub-module axi_slv_addr_gen (combinational next-address from addr/size/burst), instantiated once for reads and once for writes.

Test Plan:
- Single read: the SRAM holds 0x1234_5678 at word 0x10. Send AR with addr 0x40, len 0, size 2, id 3 → rvalid at T+3 with rdata 0x12345678, rid 3, rresp 0, rlast 1.
- Partial write: AW addr 0x44, len 0; W data 0xAABBCCDD, wstrb 4'b0011, wlast 1 → ram_we 0011 at word 0x11, then bvalid with bresp 0, and the word reads back as 0x????CCDD (upper bytes unchanged).
- INCR read: 4 beats (arlen 3) from 0x100 with rready low for 2 cycles on beat 2 → ram_addr sequence 0x40, 0x41, 0x42, 0x43; rdata stable while stalled; rlast on beat 4 only.
- Contention: a read burst and a write burst (len 1 each) both requesting in the same cycle → grants alternate between write and read, with exactly one ram_en per cycle and both transactions completing with OKAY.
- Early wlast: awlen 2 with wlast on beat 2 → three SRAM writes, then bresp 2'b10.
- Reset mid-burst: assert reset during R_DATA of an 8-beat read → rvalid drops immediately, arready=1 and awready=1 after reset releases, and the next single read returns correct data.

Source files
------------

// File: rtl/axi_slv_pkg.sv
// Shared definitions for the AXI3 SRAM responder: response/burst codes, FSM states, beat counting.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package axi_slv_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_REQ  = 2'd1,
    R_CAP  = 2'd2,
    R_DATA = 2'd3
  } r_state_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_t;

  // Which engine won the most recent read/write conflict.
  typedef enum logic {
    GNT_READ  = 1'b0,
    GNT_WRITE = 1'b1
  } gnt_t;

  // Only the low nibble of AxLEN matters: AXI3 bursts are at most 16 beats.
  function automatic logic [4:0] beat_count(input logic [3:0] len_lo);
    return {1'b0, len_lo} + 5'd1;
  endfunction

endpackage

// File: rtl/axi_slv_addr_gen.sv
// Next-beat byte address for an AXI burst (FIXED holds, INCR/WRAP/reserved step by the beat size).
// Latency: combinational.
// Backpressure: none; the owning engine decides when to load the result.
// Ports: addr (current byte address), size (AxSIZE, clamped to 4 bytes), burst (AxBURST),
//        next_addr (byte address of the following beat).
module axi_slv_addr_gen
  import axi_slv_pkg::*;
(
  input  logic [31:0] addr,
  input  logic [2:0]  size,
  input  logic [1:0]  burst,
  output logic [31:0] next_addr
);

  logic [31:0] step;

  always_comb begin
    // The data bus is 32 bits wide, so anything wider than a word still moves one word per beat.
    step      = (size >= 3'd2) ? 32'd4 : (32'd1 << size);
    next_addr = (burst == BURST_FIXED) ? addr : (addr + step);
  end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI3 responder mapping independent read/write engines onto one single-port 1-cycle-latency SRAM.
// Latency: AR handshake at T -> ram_en at T+1 -> rvalid at T+3 uncontended; W beats write in the accept cycle.
// Backpressure: rvalid/bvalid hold until rready/bready; wready follows the SRAM grant; AR/AW accept one burst at a time.
// Ports: AXI3 AR/R/AW/W/B channels (lock/cache/prot and wid accepted but unused),
//        SRAM port ram_en/ram_we/ram_addr/ram_wdata out, ram_rdata in (valid the cycle after a read).
module axi_sram_slave
  import axi_slv_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int ID_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ID_W-1:0]   arid,
  input  logic [31:0]       araddr,
  input  logic [7:0]        arlen,
  input  logic [2:0]        arsize,
  input  logic [1:0]        arburst,
  input  logic [1:0]        arlock,
  input  logic [3:0]        arcache,
  input  logic [2:0]        arprot,
  input  logic              arvalid,
  output logic              arready,
  output logic [ID_W-1:0]   rid,
  output logic [31:0]       rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready,
  input  logic [ID_W-1:0]   awid,
  input  logic [31:0]       awaddr,
  input  logic [7:0]        awlen,
  input  logic [2:0]        awsize,
  input  logic [1:0]        awburst,
  input  logic [1:0]        awlock,
  input  logic [3:0]        awcache,
  input  logic [2:0]        awprot,
  input  logic              awvalid,
  output logic              awready,
  input  logic [ID_W-1:0]   wid,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  input  logic              wlast,
  input  logic              wvalid,
  output logic              wready,
  output logic [ID_W-1:0]   bid,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  // Read engine state
  r_state_t        r_state;
  logic [ID_W-1:0] r_id;
  logic [31:0]     r_addr;
  logic [2:0]      r_size;
  logic [1:0]      r_burst;
  logic [4:0]      r_cnt;
  logic [31:0]     r_next;

  // Write engine state
  w_state_t        w_state;
  logic [ID_W-1:0] w_id;
  logic [31:0]     w_addr;
  logic [2:0]      w_size;
  logic [1:0]      w_burst;
  logic [4:0]      w_cnt;
  logic            w_err;
  logic [31:0]     w_next;
  logic            w_final;
  logic            w_err_nxt;

  // Arbiter
  gnt_t            last_gnt;
  logic            rd_req, wr_req, rd_gnt, wr_gnt;

  // Sideband fields and the wide part of AxLEN carry no meaning for this memory.
  logic unused_ok;
  assign unused_ok = ^{wid, arlock, arcache, arprot, awlock, awcache, awprot, arlen[7:4], awlen[7:4]};

  axi_slv_addr_gen u_rd_addr (.addr(r_addr), .size(r_size), .burst(r_burst), .next_addr(r_next));
  axi_slv_addr_gen u_wr_addr (.addr(w_addr), .size(w_size), .burst(w_burst), .next_addr(w_next));

  // A write only competes for the port when a data beat is actually offered, so an idle
  // W channel never steals slots from reads.
  assign rd_req = (r_state == R_REQ);
  assign wr_req = (w_state == W_DATA) && wvalid;
  assign rd_gnt = rd_req && (!wr_req || (last_gnt == GNT_WRITE));
  assign wr_gnt = wr_req && (!rd_req || (last_gnt == GNT_READ));

  assign wready    = wr_gnt;
  assign ram_en    = rd_gnt | wr_gnt;
  assign ram_we    = wr_gnt ? wstrb : 4'b0000;
  assign ram_addr  = wr_gnt ? w_addr[ADDR_W+1:2] : r_addr[ADDR_W+1:2];
  assign ram_wdata = wr_gnt ? wdata : 32'd0;

  assign rid = r_id;
  assign bid = w_id;

  // wlast must coincide exactly with the final counted beat.
  assign w_final   = (w_cnt == 5'd1);
  assign w_err_nxt = w_err | (wlast != w_final);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_gnt <= GNT_READ;
    end else if (rd_req && wr_req) begin
      last_gnt <= rd_gnt ? GNT_READ : GNT_WRITE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= R_IDLE;
      arready <= 1'b1;
      rvalid  <= 1'b0;
      rdata   <= 32'd0;
      rresp   <= RESP_OKAY;
      rlast   <= 1'b0;
      r_id    <= '0;
      r_addr  <= 32'd0;
      r_size  <= 3'd0;
      r_burst <= BURST_FIXED;
      r_cnt   <= 5'd0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (arvalid) begin
            r_id    <= arid;
            r_addr  <= araddr;
            r_size  <= arsize;
            r_burst <= arburst;
            r_cnt   <= beat_count(arlen[3:0]);
            // Reserved burst type still reads data but flags every beat.
            rresp   <= (arburst == BURST_RSVD) ? RESP_SLVERR : RESP_OKAY;
            arready <= 1'b0;
            r_state <= R_REQ;
          end
        end
        R_REQ: begin
          if (rd_gnt) r_state <= R_CAP;
        end
        R_CAP: begin
          rdata   <= ram_rdata;
          rlast   <= (r_cnt == 5'd1);
          rvalid  <= 1'b1;
          r_state <= R_DATA;
        end
        R_DATA: begin
          if (rready) begin
            rvalid <= 1'b0;
            rlast  <= 1'b0;
            if (rlast) begin
              arready <= 1'b1;
              r_state <= R_IDLE;
            end else begin
              r_addr  <= r_next;
              r_cnt   <= r_cnt - 5'd1;
              r_state <= R_REQ;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_state <= W_IDLE;
      awready <= 1'b1;
      bvalid  <= 1'b0;
      bresp   <= RESP_OKAY;
      w_id    <= '0;
      w_addr  <= 32'd0;
      w_size  <= 3'd0;
      w_burst <= BURST_FIXED;
      w_cnt   <= 5'd0;
      w_err   <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (awvalid) begin
            w_id    <= awid;
            w_addr  <= awaddr;
            w_size  <= awsize;
            w_burst <= awburst;
            w_cnt   <= beat_count(awlen[3:0]);
            w_err   <= (awburst == BURST_RSVD);
            awready <= 1'b0;
            w_state <= W_DATA;
          end
        end
        W_DATA: begin
          if (wr_gnt) begin
            if (w_final) begin
              bvalid  <= 1'b1;
              bresp   <= w_err_nxt ? RESP_SLVERR : RESP_OKAY;
              w_state <= W_RESP;
            end else begin
              w_addr <= w_next;
              w_cnt  <= w_cnt - 5'd1;
              w_err  <= w_err_nxt;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid  <= 1'b0;
            awready <= 1'b1;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

endmodule
